// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared maze constants, tile codes and checker state encoding
package maze_pkg;

  localparam int MAZE_W_DEF = 20;
  localparam int MAZE_H_DEF = 15;

  localparam int TILE_PATH    = 0;
  localparam int TILE_WALL    = 1;
  localparam int TILE_GOAL    = 2;
  localparam int TILE_BONUS   = 3;
  localparam int TILE_PENALTY = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_READ   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DECIDE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/move_legality_checker_if.sv
// rtl/move_legality_checker_if.sv - move-request / doneLegal handshake bundle
interface move_legality_checker_if #(
  parameter int COORD_W = 5
);
  logic               check_req;
  logic [COORD_W-1:0] changedX;
  logic [COORD_W-1:0] changedY;
  logic [COORD_W-1:0] currentX;
  logic [COORD_W-1:0] currentY;
  logic               busy;
  logic               doneLegal;
  logic               isLegal;
  logic               hitBonus;
  logic               hitPenalty;
  logic               gameWon;
  logic               req_dropped;

  modport master (
    output check_req, changedX, changedY, currentX, currentY,
    input  busy, doneLegal, isLegal, hitBonus, hitPenalty, gameWon, req_dropped
  );

  modport slave (
    input  check_req, changedX, changedY, currentX, currentY,
    output busy, doneLegal, isLegal, hitBonus, hitPenalty, gameWon, req_dropped
  );
endinterface

// File: rtl/tile_addr_gen.sv
// rtl/tile_addr_gen.sv - combinational tile address Y*MAZE_W+X and bounds flag
module tile_addr_gen
  import maze_pkg::*;
#(
  parameter int MAZE_W  = MAZE_W_DEF,
  parameter int MAZE_H  = MAZE_H_DEF,
  parameter int COORD_W = 5,
  parameter int ADDR_W  = 9
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr,
  output logic               in_bounds
);
  localparam logic [COORD_W-1:0] W_LIM = COORD_W'(MAZE_W);
  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(MAZE_H);

  // Unsigned compare also rejects 0-1 wrapping to the all-ones coordinate.
  assign in_bounds = (x < W_LIM) && (y < H_LIM);
  assign addr      = ADDR_W'(y) * ADDR_W'(MAZE_W) + ADDR_W'(x);
endmodule

// File: rtl/move_legality_checker.sv
// rtl/move_legality_checker.sv - bounds check plus tile RAM lookup returning move verdicts
module move_legality_checker
  import maze_pkg::*;
#(
  parameter int MAZE_W      = MAZE_W_DEF,
  parameter int MAZE_H      = MAZE_H_DEF,
  parameter int COORD_W     = 5,
  parameter int ADDR_W      = 9,
  parameter int TILE_W      = 3,
  parameter int MEM_LATENCY = 1
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     externalReset,
  move_legality_checker_if.slave   mv,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [TILE_W-1:0]        mem_rdata
);
  localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);

  state_t              state;
  logic [1:0]          lat_cnt;
  logic [TILE_W-1:0]   tile_q;
  logic                fast_q;
  logic                fast_legal_q;
  logic [ADDR_W-1:0]   addr_c;
  logic                in_bounds_c;
  logic                null_move_c;
  logic                t_goal, t_bonus, t_penalty, t_legal;

  tile_addr_gen #(
    .MAZE_W (MAZE_W),
    .MAZE_H (MAZE_H),
    .COORD_W(COORD_W),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .x        (mv.changedX),
    .y        (mv.changedY),
    .addr     (addr_c),
    .in_bounds(in_bounds_c)
  );

  assign null_move_c = (mv.changedX == mv.currentX) && (mv.changedY == mv.currentY);
  assign t_goal      = (tile_q == TILE_W'(TILE_GOAL));
  assign t_bonus     = (tile_q == TILE_W'(TILE_BONUS));
  assign t_penalty   = (tile_q == TILE_W'(TILE_PENALTY));
  assign t_legal     = (tile_q == TILE_W'(TILE_PATH)) || t_goal || t_bonus || t_penalty;

  // The CHECK rules are resolved at acceptance so mem_rd/mem_addr can be registered
  // and already be on the bus during the CHECK cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;  lat_cnt <= '0;  tile_q <= '0;  fast_q <= 1'b0;  fast_legal_q <= 1'b0;
      mem_rd <= 1'b0;  mem_addr <= '0;  mv.busy <= 1'b0;  mv.doneLegal <= 1'b0;
      mv.isLegal <= 1'b0;  mv.hitBonus <= 1'b0;  mv.hitPenalty <= 1'b0;
      mv.gameWon <= 1'b0;  mv.req_dropped <= 1'b0;
    end else if (externalReset) begin
      state <= ST_IDLE;  lat_cnt <= '0;  tile_q <= '0;  fast_q <= 1'b0;  fast_legal_q <= 1'b0;
      mem_rd <= 1'b0;  mem_addr <= '0;  mv.busy <= 1'b0;  mv.doneLegal <= 1'b0;
      mv.isLegal <= 1'b0;  mv.hitBonus <= 1'b0;  mv.hitPenalty <= 1'b0;
      mv.gameWon <= 1'b0;  mv.req_dropped <= 1'b0;
    end else begin
      mv.req_dropped <= mv.check_req && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (mv.check_req) begin
            mv.busy <= 1'b1;
            state   <= ST_CHECK;
            if (mv.gameWon || !in_bounds_c) begin
              fast_q       <= 1'b1;
              fast_legal_q <= 1'b0;
            end else if (null_move_c) begin
              fast_q       <= 1'b1;
              fast_legal_q <= 1'b1;
            end else begin
              fast_q   <= 1'b0;
              mem_rd   <= 1'b1;
              mem_addr <= addr_c;
            end
          end
        end
        ST_CHECK: begin
          mem_rd <= 1'b0;
          if (fast_q) begin
            mv.doneLegal <= 1'b1;
            mv.isLegal   <= fast_legal_q;
            state        <= ST_DONE;
          end else begin
            lat_cnt <= LAT_M1;
            state   <= ST_READ;
          end
        end
        ST_READ, ST_WAIT: begin
          if (lat_cnt == 2'd0) begin
            tile_q <= mem_rdata;
            state  <= ST_DECIDE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
            state   <= ST_WAIT;
          end
        end
        ST_DECIDE: begin
          mv.doneLegal  <= 1'b1;
          mv.isLegal    <= t_legal;
          mv.hitBonus   <= t_bonus;
          mv.hitPenalty <= t_penalty;
          if (t_goal) mv.gameWon <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          mv.doneLegal  <= 1'b0;
          mv.hitBonus   <= 1'b0;
          mv.hitPenalty <= 1'b0;
          mv.busy       <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_move_legality_checker.sv
// tb/tb_move_legality_checker.sv - directed self-checking bench for move_legality_checker
module tb_move_legality_checker;
  import maze_pkg::*;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       externalReset = 1'b0;
  logic       mem_rd;
  logic [8:0] mem_addr;
  logic [2:0] mem_rdata = 3'd0;
  logic [2:0] tiles [512];
  int         total = 0;
  int         bad = 0;
  int         lat;
  int         extra;

  always #5 clock = ~clock;

  move_legality_checker_if #(.COORD_W(5)) mv();

  move_legality_checker dut (
    .clock        (clock),
    .resetn       (resetn),
    .externalReset(externalReset),
    .mv           (mv),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata)
  );

  // One-cycle-latency tile RAM
  always @(posedge clock) if (mem_rd) mem_rdata <= tiles[mem_addr];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int x, input int y);
    mv.check_req = 1'b1;
    mv.changedX  = 5'(x);
    mv.changedY  = 5'(y);
    step();
    mv.check_req = 1'b0;
  endtask

  task automatic wait_done(input int start, output int l);
    l = start;
    while (mv.doneLegal !== 1'b1 && l < 20) begin
      step();
      l++;
    end
  endtask

  task automatic count_dones(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (mv.doneLegal === 1'b1) c++;
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) tiles[i] = 3'(TILE_PATH);
    tiles[105] = 3'(TILE_WALL);
    tiles[27]  = 3'(TILE_GOAL);
    tiles[21]  = 3'(TILE_BONUS);
    tiles[22]  = 3'(TILE_PENALTY);
    tiles[84]  = 3'd6;
    mv.check_req = 1'b0;
    mv.changedX  = 5'd0;
    mv.changedY  = 5'd0;
    mv.currentX  = 5'd10;
    mv.currentY  = 5'd10;
    step(); step();
    chk("rst_busy", 32'(mv.busy), 0);
    chk("rst_done", 32'(mv.doneLegal), 0);
    chk("rst_legal", 32'(mv.isLegal), 0);
    chk("rst_won", 32'(mv.gameWon), 0);
    chk("rst_rd", 32'(mem_rd), 0);
    resetn = 1'b1;
    step();

    // PATH at (3,2)
    send(3, 2);
    chk("t1_rd", 32'(mem_rd), 1);
    chk("t1_addr", 32'(mem_addr), 43);
    chk("t1_busy", 32'(mv.busy), 1);
    step();
    chk("t1_rd_pulse", 32'(mem_rd), 0);
    wait_done(2, lat);
    chk("t1_lat", 32'(lat), 4);
    chk("t1_legal", 32'(mv.isLegal), 1);
    chk("t1_drop", 32'(mv.req_dropped), 0);
    step();
    chk("t1_done_pulse", 32'(mv.doneLegal), 0);
    chk("t1_busy_off", 32'(mv.busy), 0);

    // X wrapped to 31
    send(31, 0);
    chk("t2_rd", 32'(mem_rd), 0);
    wait_done(1, lat);
    chk("t2_lat", 32'(lat), 2);
    chk("t2_legal", 32'(mv.isLegal), 0);
    step();

    // WALL at (5,5)
    send(5, 5);
    chk("t3_addr", 32'(mem_addr), 105);
    wait_done(1, lat);
    chk("t3_lat", 32'(lat), 4);
    chk("t3_legal", 32'(mv.isLegal), 0);
    chk("t3_bonus", 32'(mv.hitBonus), 0);
    chk("t3_pen", 32'(mv.hitPenalty), 0);
    step();

    // Code 6 is a wall
    send(4, 4);
    chk("c6_addr", 32'(mem_addr), 84);
    wait_done(1, lat);
    chk("c6_legal", 32'(mv.isLegal), 0);
    step();

    // Null move and Y just past the edge
    send(10, 10);
    chk("null_rd", 32'(mem_rd), 0);
    wait_done(1, lat);
    chk("null_lat", 32'(lat), 2);
    chk("null_legal", 32'(mv.isLegal), 1);
    step();
    send(0, 15);
    chk("ybnd_rd", 32'(mem_rd), 0);
    wait_done(1, lat);
    chk("ybnd_lat", 32'(lat), 2);
    chk("ybnd_legal", 32'(mv.isLegal), 0);
    step();

    // BONUS then PENALTY
    send(1, 1);
    wait_done(1, lat);
    chk("t5_b_legal", 32'(mv.isLegal), 1);
    chk("t5_b_bonus", 32'(mv.hitBonus), 1);
    chk("t5_b_pen", 32'(mv.hitPenalty), 0);
    step();
    chk("t5_b_oneshot", 32'(mv.hitBonus), 0);
    send(2, 1);
    wait_done(1, lat);
    chk("t5_p_legal", 32'(mv.isLegal), 1);
    chk("t5_p_bonus", 32'(mv.hitBonus), 0);
    chk("t5_p_pen", 32'(mv.hitPenalty), 1);
    step();

    // Second request while busy is dropped
    send(1, 1);
    chk("t6_addr", 32'(mem_addr), 21);
    mv.check_req = 1'b1;
    mv.changedX  = 5'd5;
    mv.changedY  = 5'd5;
    step();
    mv.check_req = 1'b0;
    chk("t6_dropped", 32'(mv.req_dropped), 1);
    wait_done(2, lat);
    chk("t6_lat", 32'(lat), 4);
    chk("t6_legal", 32'(mv.isLegal), 1);
    chk("t6_bonus", 32'(mv.hitBonus), 1);
    count_dones(6, extra);
    chk("t6_single_done", 32'(extra), 0);

    // Request during DONE is dropped too
    send(3, 2);
    wait_done(1, lat);
    mv.check_req = 1'b1;
    mv.changedX  = 5'd5;
    mv.changedY  = 5'd5;
    step();
    mv.check_req = 1'b0;
    chk("done_drop", 32'(mv.req_dropped), 1);
    chk("done_drop_busy", 32'(mv.busy), 0);

    // GOAL is sticky and blocks further moves
    send(7, 1);
    wait_done(1, lat);
    chk("t4_lat", 32'(lat), 4);
    chk("t4_legal", 32'(mv.isLegal), 1);
    chk("t4_won", 32'(mv.gameWon), 1);
    step();
    chk("t4_won_sticky", 32'(mv.gameWon), 1);
    send(3, 2);
    chk("t4_rd", 32'(mem_rd), 0);
    wait_done(1, lat);
    chk("t4_lat2", 32'(lat), 2);
    chk("t4_legal2", 32'(mv.isLegal), 0);
    step();

    // externalReset clears gameWon and beats a simultaneous request
    externalReset = 1'b1;
    step();
    externalReset = 1'b0;
    chk("xr_won", 32'(mv.gameWon), 0);
    mv.check_req  = 1'b1;
    mv.changedX   = 5'd3;
    mv.changedY   = 5'd2;
    externalReset = 1'b1;
    step();
    mv.check_req  = 1'b0;
    externalReset = 1'b0;
    chk("xr_req_busy", 32'(mv.busy), 0);
    chk("xr_req_rd", 32'(mem_rd), 0);

    // externalReset while the RAM read is outstanding
    send(3, 2);
    step();
    externalReset = 1'b1;
    step();
    externalReset = 1'b0;
    chk("xr_mid_busy", 32'(mv.busy), 0);
    chk("xr_mid_done", 32'(mv.doneLegal), 0);
    chk("xr_mid_won", 32'(mv.gameWon), 0);
    count_dones(6, extra);
    chk("xr_mid_nodone", 32'(extra), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
